// File: rtl/bht_access_ctrl.sv
// Branch history table access controller.
// Owns a table of 2-bit saturating counters with a single read-modify-write
// port. IF-stage lookups and buffered EX/MEM resolution updates share that
// port. After reset the table is walked once to clear every counter to 00.
//
//   state | meaning
//   INIT  | clearing table, one entry per cycle; no lookups or updates accepted
//   RUN   | one access per cycle: forced drain when full, else lookup, else drain
module bht_access_ctrl #(
    parameter int ENTRIES  = 16,
    parameter int IDX_W    = 4,
    parameter int UQ_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lk_valid,
    input  logic [IDX_W-1:0] lk_idx,
    output logic             lk_ready,
    output logic             pred_valid,
    output logic             pred_taken,
    input  logic             up_valid,
    input  logic [IDX_W-1:0] up_idx,
    input  logic             up_taken,
    output logic             up_ready,
    output logic             init_busy
);

    localparam int PTR_W = (UQ_DEPTH > 1) ? $clog2(UQ_DEPTH) : 1;
    localparam int CNT_W = $clog2(UQ_DEPTH + 1);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(UQ_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(UQ_DEPTH - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   init_ptr_q;

    logic [1:0]         bht_q [ENTRIES];

    logic [IDX_W-1:0]   fifo_idx_q [UQ_DEPTH];
    logic               fifo_tkn_q [UQ_DEPTH];
    logic [PTR_W-1:0]   head_q, tail_q;
    logic [CNT_W-1:0]   count_q, count_d;

    logic               fifo_full;
    logic               init_wr;
    logic               lk_acc;
    logic               enq;
    logic               deq;

    logic [IDX_W-1:0]   head_idx;
    logic               head_tkn;
    logic [1:0]         head_cur;

    // Saturating 2-bit counter step; clamps at 00 and 11 instead of wrapping.
    function automatic logic [1:0] sat_step(input logic [1:0] cur, input logic taken);
        if (taken) begin
            return (cur == 2'b11) ? cur : cur + 2'd1;
        end
        return (cur == 2'b00) ? cur : cur - 2'd1;
    endfunction

    // Pointer advance with explicit wrap so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign fifo_full = (count_q == FULL_CNT);
    assign head_idx  = fifo_idx_q[head_q];
    assign head_tkn  = fifo_tkn_q[head_q];
    assign head_cur  = bht_q[head_idx];

    // Next-state and port arbitration: a full FIFO wins over lookups so
    // updates can never starve; otherwise lookups win over opportunistic drains.
    always_comb begin
        state_d   = state_q;
        init_busy = 1'b0;
        lk_ready  = 1'b0;
        up_ready  = 1'b0;
        init_wr   = 1'b0;
        lk_acc    = 1'b0;
        enq       = 1'b0;
        deq       = 1'b0;
        unique case (state_q)
            ST_INIT: begin
                init_busy = 1'b1;
                init_wr   = 1'b1;
                if (init_ptr_q == LAST_IDX) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                lk_ready = !fifo_full;
                up_ready = !fifo_full;
                enq      = up_valid && !fifo_full;
                if (fifo_full) begin
                    deq = 1'b1;
                end else if (lk_valid) begin
                    lk_acc = 1'b1;
                end else if (count_q != '0) begin
                    deq = 1'b1;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    // FIFO occupancy: simultaneous enqueue and dequeue leaves it unchanged.
    always_comb begin
        count_d = count_q;
        unique case ({enq, deq})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // State register and clear pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_INIT;
            init_ptr_q <= '0;
        end else begin
            state_q <= state_d;
            if (init_wr) begin
                init_ptr_q <= init_ptr_q + IDX_W'(1);
            end
        end
    end

    // FIFO control: pointers and count; reset discards anything pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            count_q <= count_d;
            if (enq) begin
                tail_q <= ptr_next(tail_q);
            end
            if (deq) begin
                head_q <= ptr_next(head_q);
            end
        end
    end

    // FIFO payload storage; contents are only meaningful below count_q.
    always_ff @(posedge clk) begin
        if (!rst && enq) begin
            fifo_idx_q[tail_q] <= up_idx;
            fifo_tkn_q[tail_q] <= up_taken;
        end
    end

    // Single table write port: INIT clear or a drained update, never both.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (init_wr) begin
                bht_q[init_ptr_q] <= 2'b00;
            end else if (deq) begin
                bht_q[head_idx] <= sat_step(head_cur, head_tkn);
            end
        end
    end

    // Prediction output: one cycle after an accepted lookup; taken holds otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            pred_valid <= 1'b0;
            pred_taken <= 1'b0;
        end else begin
            pred_valid <= lk_acc;
            if (lk_acc) begin
                pred_taken <= bht_q[lk_idx][1];
            end
        end
    end

endmodule

// File: tb/tb_bht_access_ctrl.sv
// Directed bench for bht_access_ctrl. Expected predictions are queued when a
// lookup is accepted; a negedge monitor pops them whenever pred_valid is seen.
module tb_bht_access_ctrl;

    logic       clk;
    logic       rst;
    logic       lk_valid;
    logic [3:0] lk_idx;
    logic       lk_ready;
    logic       pred_valid;
    logic       pred_taken;
    logic       up_valid;
    logic [3:0] up_idx;
    logic       up_taken;
    logic       up_ready;
    logic       init_busy;

    int checks = 0;
    int errors = 0;
    bit exp_q[$];

    bht_access_ctrl #(.ENTRIES(16), .IDX_W(4), .UQ_DEPTH(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .lk_valid   (lk_valid),
        .lk_idx     (lk_idx),
        .lk_ready   (lk_ready),
        .pred_valid (pred_valid),
        .pred_taken (pred_taken),
        .up_valid   (up_valid),
        .up_idx     (up_idx),
        .up_taken   (up_taken),
        .up_ready   (up_ready),
        .init_busy  (init_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1, "watchdog");
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (pred_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pred actual pred_valid=1 required no prediction");
            end else begin
                bit e;
                e = exp_q.pop_front();
                if (pred_taken !== e) begin
                    errors++;
                    $display("FAIL pred_taken actual %0d required %0d", pred_taken, e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, req);
        end
    endtask

    task automatic lookup(input logic [3:0] idx, input bit e);
        int n;
        lk_valid = 1'b1;
        lk_idx   = idx;
        n = 0;
        while (lk_ready !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        if (lk_ready !== 1'b1) begin
            check("lookup_timeout", 32'(lk_ready), 32'd1);
        end else begin
            exp_q.push_back(e);
        end
        step();
        lk_valid = 1'b0;
    endtask

    task automatic upd(input logic [3:0] idx, input bit t);
        int n;
        up_valid = 1'b1;
        up_idx   = idx;
        up_taken = t;
        n = 0;
        while (up_ready !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        if (up_ready !== 1'b1) check("update_timeout", 32'(up_ready), 32'd1);
        step();
        up_valid = 1'b0;
    endtask

    task automatic count_init(input string name);
        int n;
        bit rdy_seen;
        n = 0;
        rdy_seen = 1'b0;
        while (init_busy === 1'b1 && n < 100) begin
            if (lk_ready !== 1'b0 || up_ready !== 1'b0) rdy_seen = 1'b1;
            n++;
            step();
        end
        check({name, "_init_cycles"}, 32'(n), 32'd16);
        check({name, "_ready_in_init"}, 32'(rdy_seen), 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        lk_valid = 1'b1;
        lk_idx   = 4'd0;
        up_valid = 1'b1;
        up_idx   = 4'd0;
        up_taken = 1'b1;

        // Reset, with requests held high through INIT (they must be ignored).
        step();
        rst = 1'b0;
        check("rst_pred_valid", 32'(pred_valid), 32'd0);
        check("rst_pred_taken", 32'(pred_taken), 32'd0);
        check("rst_init_busy", 32'(init_busy), 32'd1);
        count_init("first");
        lk_valid = 1'b0;
        up_valid = 1'b0;
        check("run_lk_ready", 32'(lk_ready), 32'd1);
        check("run_up_ready", 32'(up_ready), 32'd1);
        for (int i = 0; i < 16; i++) lookup(4'(i), 1'b0);
        idle(2);

        // Idx 5: three taken -> 11, then not-taken -> 10, then -> 01.
        for (int i = 0; i < 3; i++) upd(4'd5, 1'b1);
        idle(4);
        lookup(4'd5, 1'b1);
        upd(4'd5, 1'b0);
        idle(4);
        lookup(4'd5, 1'b1);
        upd(4'd5, 1'b0);
        idle(4);
        lookup(4'd5, 1'b0);

        // Idx 2: underflow clamp then overflow clamp.
        for (int i = 0; i < 5; i++) upd(4'd2, 1'b0);
        upd(4'd2, 1'b1);
        idle(4);
        lookup(4'd2, 1'b0);
        for (int i = 0; i < 4; i++) upd(4'd2, 1'b1);
        idle(4);
        lookup(4'd2, 1'b1);
        upd(4'd2, 1'b0);
        idle(4);
        lookup(4'd2, 1'b1);

        // Lookups held high while two updates fill the FIFO.
        lk_valid = 1'b1;
        lk_idx   = 4'd9;
        up_valid = 1'b1;
        up_idx   = 4'd11;
        up_taken = 1'b1;
        check("fill0_lk_ready", 32'(lk_ready), 32'd1);
        exp_q.push_back(1'b0);
        step();
        check("fill1_lk_ready", 32'(lk_ready), 32'd1);
        check("fill1_up_ready", 32'(up_ready), 32'd1);
        exp_q.push_back(1'b0);
        step();
        up_valid = 1'b0;
        check("full_lk_ready", 32'(lk_ready), 32'd0);
        check("full_up_ready", 32'(up_ready), 32'd0);
        step();
        check("drained_lk_ready", 32'(lk_ready), 32'd1);
        exp_q.push_back(1'b0);
        step();
        lk_valid = 1'b0;
        idle(4);
        lookup(4'd11, 1'b1);

        // Simultaneous enqueue and drain at count 1 keeps count at 1.
        idle(2);
        up_valid = 1'b1;
        up_idx   = 4'd7;
        up_taken = 1'b1;
        step();
        step();
        up_idx   = 4'd8;
        lk_valid = 1'b1;
        lk_idx   = 4'd0;
        check("pre_fill_lk_ready", 32'(lk_ready), 32'd1);
        exp_q.push_back(1'b0);
        step();
        up_valid = 1'b0;
        lk_valid = 1'b0;
        check("count_held_lk_ready", 32'(lk_ready), 32'd0);
        check("count_held_up_ready", 32'(up_ready), 32'd0);
        idle(4);
        lookup(4'd7, 1'b1);
        lookup(4'd8, 1'b0);

        // Reset while running with a full FIFO and entry 3 at 11.
        for (int i = 0; i < 3; i++) upd(4'd3, 1'b1);
        idle(4);
        lookup(4'd3, 1'b1);
        lk_valid = 1'b1;
        lk_idx   = 4'd3;
        up_valid = 1'b1;
        up_idx   = 4'd3;
        up_taken = 1'b0;
        exp_q.push_back(1'b1);
        step();
        exp_q.push_back(1'b1);
        step();
        check("prerst_full", 32'(lk_ready), 32'd0);
        rst      = 1'b1;
        lk_valid = 1'b0;
        up_valid = 1'b0;
        step();
        rst = 1'b0;
        check("rst2_pred_valid", 32'(pred_valid), 32'd0);
        check("rst2_init_busy", 32'(init_busy), 32'd1);
        count_init("second");
        check("rst2_lk_ready", 32'(lk_ready), 32'd1);
        check("rst2_up_ready", 32'(up_ready), 32'd1);
        idle(3);
        lookup(4'd3, 1'b0);
        lookup(4'd5, 1'b0);

        idle(3);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bht_access_ctrl.md
Name: bht_access_ctrl

Overview:
Access controller for the branch history table (BHT): an array of ENTRIES 2-bit saturating counters with one read-modify-write access per cycle. It arbitrates that single access between IF-stage lookups and EX/MEM-stage resolution updates, buffering updates in a small FIFO. After reset it runs an init sequence that clears every entry to StronglyNotTaken (00). It replaces the single global 2-bit predictor with a per-index table.

Parameters:
ENTRIES, 16, number of 2-bit counters (power of two)
IDX_W, 4, index width, log2(ENTRIES)
UQ_DEPTH, 2, update FIFO depth (>=1)

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous active-high reset
lk_valid  in  1  IF requests a prediction
lk_idx  in  IDX_W  table index for the lookup
lk_ready  out  1  lookup accepted this cycle when lk_valid && lk_ready
pred_valid  out  1  registered; high the cycle after an accepted lookup
pred_taken  out  1  registered; MSB of the looked-up counter
up_valid  in  1  resolved branch update offered
up_idx  in  IDX_W  index to update
up_taken  in  1  resolved outcome, 1 = taken
up_ready  out  1  update enqueued when up_valid && up_ready
init_busy  out  1  high while the table clear is in progress

Behaviour:
- Reset, synchronous, at posedge with rst=1:
  - state <= INIT, init_ptr <= 0, FIFO emptied (count 0, pointers 0), pending updates discarded.
  - pred_valid <= 0, pred_taken <= 0.
  - Table contents are not touched by rst itself; INIT clears them.
- Reset asserted mid-operation has the same effect; nothing from before reset survives.
- FSM states: INIT and RUN.
- INIT:
  - Each cycle writes 00 to entry init_ptr, then init_ptr increments.
  - The cycle that writes entry ENTRIES-1 transitions to RUN.
  - INIT lasts exactly ENTRIES cycles; init_busy = (state==INIT).
  - lk_ready = 0, up_ready = 0; lk_valid and up_valid are ignored.
- RUN, combinational ready signals:
  - lk_ready = (count != UQ_DEPTH).
  - up_ready = (count != UQ_DEPTH).
- RUN, one table access per cycle, chosen in priority order:
  1. count == UQ_DEPTH: drain the FIFO head. Lookups stall (lk_ready=0), which guarantees updates cannot starve.
  2. Otherwise, lk_valid: perform the lookup.
  3. Otherwise, count > 0: drain the FIFO head.
  4. Otherwise: idle.
- Lookup:
  - pred_taken <= table[lk_idx][1]; pred_valid <= 1 (latency 1).
  - In any cycle without an accepted lookup, pred_valid <= 0 and pred_taken holds its value.
- Drain: table[head.idx] <= sat(table[head.idx], head.taken).
  - taken: 00->01, 01->10, 10->11, 11->11.
  - not taken: 11->10, 10->01, 01->00, 00->00.
  - Arithmetic is 2-bit unsigned, clamped at 0 and 3; no wrap.
- Enqueue and dequeue:
  - An enqueued entry is drainable no earlier than the next cycle.
  - Enqueue and dequeue in the same cycle: count unchanged, FIFO order preserved.
  - FIFO pointers wrap modulo UQ_DEPTH.
- Hazards:
  - Lookups read committed table state only; pending FIFO updates are not forwarded.
  - Multiple updates to the same index apply in arrival order, one drain each; no coalescing.
- Table write port: only INIT clear or drain writes; never both in one cycle.

Test Plan:
- Reset 1 cycle, then idle -> init_busy high exactly 16 cycles, lk_ready/up_ready low during INIT. Lookup every index afterwards -> pred_valid 1 cycle later, pred_taken 0 for all.
- Enqueue 3x (idx 5, taken), no lookups; lookup idx 5 -> pred_taken 1 (state 11). Then 1 not-taken -> lookup gives 1 (state 10). 2nd not-taken -> lookup gives 0 (state 01).
- 5x (idx 2, not taken) then 1x taken -> lookup idx 2 gives 0 (state 01, no underflow). 4 further taken -> lookup gives 1 (saturated at 11).
- lk_valid held high every cycle while 2 updates are enqueued back-to-back -> count reaches 2, lk_ready and up_ready drop. Head drains next cycle (count 1), lk_ready rises; lookups never blocked more than 1 cycle per full event.
- Simultaneous enqueue (idx 7 taken) and drain of (idx 7 taken) with count=1 -> count stays 1. Final lookup idx 7 after idle drain gives 1 (state 10).
- rst asserted in RUN with count=2 and entry 3 = 11 -> next cycle count 0, pred_valid 0, init_busy 1 for 16 cycles. Lookup idx 3 -> pred_taken 0.
